// File: rtl/operand_fetch_unit.sv
// Operand fetch front end: issue handshake, register file port drive, destination scoreboard, operand register.
// Optional feature: define OFU_WB_BYPASS_EN to forward same-cycle writeback data into pending sources.
module operand_fetch_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   issueValid,
    output logic                   issueReady,
    input  logic [ADDR_W-1:0]      issueSrc1,
    input  logic [ADDR_W-1:0]      issueSrc2,
    input  logic [ADDR_W-1:0]      issueDst,
    input  logic                   issueWrites,
    output logic                   opValid,
    input  logic                   opReady,
    output logic [DATA_W-1:0]      opData1,
    output logic [DATA_W-1:0]      opData2,
    output logic [ADDR_W-1:0]      opDst,
    output logic                   opWrites,
    input  logic                   wbValid,
    input  logic [ADDR_W-1:0]      wbAddr,
    input  logic [DATA_W-1:0]      wbData,
    output logic [ADDR_W-1:0]      rfReadAddr1,
    output logic [ADDR_W-1:0]      rfReadAddr2,
    input  logic [DATA_W-1:0]      rfReadData1,
    input  logic [DATA_W-1:0]      rfReadData2,
    output logic [ADDR_W-1:0]      rfWriteAddr,
    output logic                   rfWriteEnable,
    output logic [DATA_W-1:0]      rfWriteData,
    output logic [(2**ADDR_W)-1:0] pendingMask,
    output logic [CNT_W-1:0]       stallCount
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [DATA_W-1:0]        data1_q, data1_d;
    logic [DATA_W-1:0]        data2_q, data2_d;
    logic [ADDR_W-1:0]        dst_q, dst_d;
    logic                     writes_q, writes_d;
    logic [(2**ADDR_W)-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]         stall_q, stall_d;

    logic                     byp1, byp2;
    logic [DATA_W-1:0]        opnd1, opnd2;
    logic                     haz_src1, haz_src2, haz_waw, hazard;
    logic                     out_free, accept;

    assign rfReadAddr1   = issueSrc1;
    assign rfReadAddr2   = issueSrc2;
    assign rfWriteAddr   = wbAddr;
    assign rfWriteEnable = wbValid;
    assign rfWriteData   = wbData;

`ifdef OFU_WB_BYPASS_EN
    // Forward only into sources that are actually pending; a non-pending
    // source must see the file's old value like any same-cycle read.
    assign byp1  = pend_q[issueSrc1] && wbValid && (wbAddr == issueSrc1);
    assign byp2  = pend_q[issueSrc2] && wbValid && (wbAddr == issueSrc2);
    assign opnd1 = byp1 ? wbData : rfReadData1;
    assign opnd2 = byp2 ? wbData : rfReadData2;
`else
    assign byp1  = 1'b0;
    assign byp2  = 1'b0;
    assign opnd1 = rfReadData1;
    assign opnd2 = rfReadData2;
`endif

    assign haz_src1   = pend_q[issueSrc1] && !byp1;
    assign haz_src2   = pend_q[issueSrc2] && !byp2;
    assign haz_waw    = issueWrites && pend_q[issueDst];
    assign hazard     = haz_src1 || haz_src2 || haz_waw;
    assign out_free   = (state_q == ST_EMPTY) || opReady;
    assign issueReady = out_free && !hazard;
    assign accept     = issueValid && issueReady;

    always_comb begin
        state_d  = state_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        dst_d    = dst_q;
        writes_d = writes_q;
        pend_d   = pend_q;
        stall_d  = stall_q;

        unique case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (!accept && opReady) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (accept) begin
            data1_d  = opnd1;
            data2_d  = opnd2;
            dst_d    = issueDst;
            writes_d = issueWrites;
        end

        // Clear first so a same-cycle set of the same bit wins.
        if (wbValid) pend_d[wbAddr] = 1'b0;
        if (accept && issueWrites) pend_d[issueDst] = 1'b1;

        if (issueValid && hazard && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= ST_EMPTY;
            data1_q  <= '0;
            data2_q  <= '0;
            dst_q    <= '0;
            writes_q <= 1'b0;
            pend_q   <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            dst_q    <= dst_d;
            writes_q <= writes_d;
            pend_q   <= pend_d;
            stall_q  <= stall_d;
        end
    end

    assign opValid     = (state_q == ST_FULL);
    assign opData1     = data1_q;
    assign opData2     = data2_q;
    assign opDst       = dst_q;
    assign opWrites    = writes_q;
    assign pendingMask = pend_q;
    assign stallCount  = stall_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit with a behavioural register file; expectations follow OFU_WB_BYPASS_EN.
module tb_operand_fetch_unit;

    logic        clk;
    logic        rstN;
    logic        issueValid, issueReady;
    logic [3:0]  issueSrc1, issueSrc2, issueDst;
    logic        issueWrites;
    logic        opValid, opReady;
    logic [31:0] opData1, opData2;
    logic [3:0]  opDst;
    logic        opWrites;
    logic        wbValid;
    logic [3:0]  wbAddr;
    logic [31:0] wbData;
    logic [3:0]  rfReadAddr1, rfReadAddr2, rfWriteAddr;
    logic [31:0] rfReadData1, rfReadData2, rfWriteData;
    logic        rfWriteEnable;
    logic [15:0] pendingMask, stallCount;

    logic [31:0] rf [16];

    int checks = 0;
    int errors = 0;

    operand_fetch_unit dut (
        .clk(clk), .rstN(rstN),
        .issueValid(issueValid), .issueReady(issueReady),
        .issueSrc1(issueSrc1), .issueSrc2(issueSrc2),
        .issueDst(issueDst), .issueWrites(issueWrites),
        .opValid(opValid), .opReady(opReady),
        .opData1(opData1), .opData2(opData2),
        .opDst(opDst), .opWrites(opWrites),
        .wbValid(wbValid), .wbAddr(wbAddr), .wbData(wbData),
        .rfReadAddr1(rfReadAddr1), .rfReadAddr2(rfReadAddr2),
        .rfReadData1(rfReadData1), .rfReadData2(rfReadData2),
        .rfWriteAddr(rfWriteAddr), .rfWriteEnable(rfWriteEnable),
        .rfWriteData(rfWriteData),
        .pendingMask(pendingMask), .stallCount(stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rfReadData1 = rf[rfReadAddr1];
    assign rfReadData2 = rf[rfReadAddr2];
    always @(posedge clk) if (rfWriteEnable) rf[rfWriteAddr] <= rfWriteData;

    typedef struct packed {
        logic        iv;
        logic [3:0]  s1, s2, d;
        logic        w;
        logic        wbv;
        logic [3:0]  wba;
        logic [31:0] wbd;
        logic        ordy;
        logic        x_rdy;
        logic        x_ov;
        logic [31:0] x_d1, x_d2;
        logic [3:0]  x_dst;
        logic        x_wr;
        logic [15:0] x_pm;
        logic [15:0] x_sc;
    } vec_t;

`ifdef OFU_WB_BYPASS_EN
    localparam logic [15:0] SC_RAW = 16'd5;
`else
    localparam logic [15:0] SC_RAW = 16'd6;
`endif

    function automatic vec_t mk(
        input logic iv, input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
        input logic w, input logic wbv, input logic [3:0] wba, input logic [31:0] wbd,
        input logic ordy, input logic x_rdy, input logic x_ov, input logic [31:0] x_d1,
        input logic [31:0] x_d2, input logic [3:0] x_dst, input logic x_wr,
        input logic [15:0] x_pm, input logic [15:0] x_sc);
        vec_t v;
        v.iv = iv; v.s1 = s1; v.s2 = s2; v.d = d; v.w = w;
        v.wbv = wbv; v.wba = wba; v.wbd = wbd; v.ordy = ordy;
        v.x_rdy = x_rdy; v.x_ov = x_ov; v.x_d1 = x_d1; v.x_d2 = x_d2;
        v.x_dst = x_dst; v.x_wr = x_wr; v.x_pm = x_pm; v.x_sc = x_sc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called shortly after a rising edge: drive, check combinational outputs, clock, check registered outputs.
    task automatic apply(input vec_t v, input string tag);
        issueValid  = v.iv;
        issueSrc1   = v.s1;
        issueSrc2   = v.s2;
        issueDst    = v.d;
        issueWrites = v.w;
        wbValid     = v.wbv;
        wbAddr      = v.wba;
        wbData      = v.wbd;
        opReady     = v.ordy;
        #2;
        chk({tag, ".issueReady"}, {31'd0, issueReady}, {31'd0, v.x_rdy});
        chk({tag, ".rfReadAddr"}, {24'd0, rfReadAddr1, rfReadAddr2}, {24'd0, v.s1, v.s2});
        chk({tag, ".rfWrite"}, {27'd0, rfWriteEnable, rfWriteAddr}, {27'd0, v.wbv, v.wba});
        @(posedge clk);
        #1;
        chk({tag, ".opValid"}, {31'd0, opValid}, {31'd0, v.x_ov});
        chk({tag, ".pendingMask"}, {16'd0, pendingMask}, {16'd0, v.x_pm});
        chk({tag, ".stallCount"}, {16'd0, stallCount}, {16'd0, v.x_sc});
        if (v.x_ov) begin
            chk({tag, ".opData1"}, opData1, v.x_d1);
            chk({tag, ".opData2"}, opData2, v.x_d2);
            chk({tag, ".opDstWr"}, {27'd0, opWrites, opDst}, {27'd0, v.x_wr, v.x_dst});
        end
    endtask

    vec_t vecs [13];

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0, 1, 6, 70,  1, 1, 0, 0,  0,  0, 0, 16'h0000, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1, 2, 30,  1, 1, 0, 0,  0,  0, 0, 16'h0000, 0);
        vecs[2]  = mk(1, 6, 2, 5, 1, 0, 0, 0,   1, 1, 1, 70, 30, 5, 1, 16'h0020, 0);
        vecs[3]  = mk(1, 2, 6, 3, 1, 0, 0, 0,   0, 0, 1, 70, 30, 5, 1, 16'h0020, 0);
        vecs[4]  = mk(1, 2, 6, 3, 1, 0, 0, 0,   0, 0, 1, 70, 30, 5, 1, 16'h0020, 0);
        vecs[5]  = mk(1, 2, 6, 3, 1, 0, 0, 0,   1, 1, 1, 30, 70, 3, 1, 16'h0028, 0);
        vecs[6]  = mk(1, 6, 6, 3, 1, 0, 0, 0,   1, 0, 0, 0,  0,  0, 0, 16'h0028, 1);
        vecs[7]  = mk(1, 6, 6, 3, 1, 0, 0, 0,   1, 0, 0, 0,  0,  0, 0, 16'h0028, 2);
        vecs[8]  = mk(1, 6, 6, 3, 1, 1, 3, 55,  1, 0, 0, 0,  0,  0, 0, 16'h0020, 3);
        vecs[9]  = mk(1, 6, 6, 3, 1, 0, 0, 0,   1, 1, 1, 70, 70, 3, 1, 16'h0028, 3);
        vecs[10] = mk(1, 2, 6, 4, 1, 1, 4, 44,  1, 1, 1, 30, 70, 4, 1, 16'h0038, 3);
        vecs[11] = mk(0, 2, 6, 4, 1, 1, 5, 100, 1, 0, 0, 0,  0,  0, 0, 16'h0018, 3);
        vecs[12] = mk(0, 0, 0, 0, 0, 1, 9, 9,   1, 1, 0, 0,  0,  0, 0, 16'h0018, 3);

        rstN = 1'b0;
        issueValid = 0; issueSrc1 = 0; issueSrc2 = 0; issueDst = 0; issueWrites = 0;
        opReady = 1; wbValid = 1; wbAddr = 0; wbData = 0;
        #2;
        chk("reset.rfWriteEnable", {31'd0, rfWriteEnable}, 32'd1);
        chk("reset.opValid", {31'd0, opValid}, 32'd0);
        chk("reset.pendingMask", {16'd0, pendingMask}, 32'd0);
        chk("reset.stallCount", {16'd0, stallCount}, 32'd0);
        chk("reset.opData", opData1 | opData2, 32'd0);
        chk("reset.opDstWr", {27'd0, opWrites, opDst}, 32'd0);
        wbValid = 0;
        @(posedge clk); #3;
        rstN = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // RAW on r4 resolved by its writeback.
        apply(mk(1, 4, 2, 7, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 16'h0018, 4), "raw_a");
        apply(mk(1, 4, 2, 7, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 16'h0018, 5), "raw_b");
`ifdef OFU_WB_BYPASS_EN
        apply(mk(1, 4, 2, 7, 0, 1, 4, 200, 1, 1, 1, 200, 30, 7, 0, 16'h0008, SC_RAW), "raw_byp");
`else
        apply(mk(1, 4, 2, 7, 0, 1, 4, 200, 1, 0, 0, 0, 0, 0, 0, 16'h0008, SC_RAW), "raw_wb");
        apply(mk(1, 4, 2, 7, 0, 0, 0, 0,   1, 1, 1, 200, 30, 7, 0, 16'h0008, SC_RAW), "raw_acc");
`endif
        apply(mk(0, 0, 0, 0, 0, 1, 3, 1,   1, 1, 0, 0, 0, 0, 0, 16'h0000, SC_RAW), "drain");

        // Build opValid=1, pendingMask=0x0024 and stall on r5 under backpressure, then reset mid-cycle.
        apply(mk(1, 6, 6, 5, 1, 0, 0, 0,   1, 1, 1, 70, 70, 5, 1, 16'h0020, SC_RAW), "fill_a");
        apply(mk(1, 6, 6, 2, 1, 0, 0, 0,   1, 1, 1, 70, 70, 2, 1, 16'h0024, SC_RAW), "fill_b");
        apply(mk(1, 5, 6, 8, 0, 0, 0, 0,   0, 0, 1, 70, 70, 2, 1, 16'h0024, SC_RAW + 16'd1), "stall");
        #2;
        rstN = 1'b0;
        #1;
        chk("async.opValid", {31'd0, opValid}, 32'd0);
        chk("async.pendingMask", {16'd0, pendingMask}, 32'd0);
        chk("async.stallCount", {16'd0, stallCount}, 32'd0);
        chk("async.opData", opData1 | opData2, 32'd0);
        @(posedge clk); #3;
        rstN = 1'b1;
        @(posedge clk); #1;
        apply(mk(1, 6, 2, 1, 1, 0, 0, 0,   1, 1, 1, 70, 30, 1, 1, 16'h0002, 0), "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
# operand_fetch_unit

Initiator-side front end of the CPU register file. Accepts decoded instructions over a valid/ready handshake, drives the register file read ports, and registers the two source operands for the execute stage. Drives the register file write port from the writeback bus. Tracks outstanding destination writes in a scoreboard, so dependent instructions stall or are bypassed instead of reading stale data.

## Interface
- DATA_W, 32, operand/register width
- ADDR_W, 4, register address width (2^ADDR_W registers)
- CNT_W, 16, stall counter width

- clk  in  1  clock; all state updates on rising edge
- rstN  in  1  asynchronous, active-low reset
- issueValid  in  1  decoded instruction present
- issueReady  out  1  instruction accepted this cycle when high with issueValid
- issueSrc1, issueSrc2  in  ADDR_W  source register addresses
- issueDst  in  ADDR_W  destination register address
- issueWrites  in  1  instruction will write issueDst
- opValid  out  1  operand bundle valid
- opReady  in  1  execute stage consumes bundle
- opData1, opData2  out  DATA_W  registered source operands
- opDst  out  ADDR_W  registered destination
- opWrites  out  1  registered issueWrites
- wbValid  in  1  writeback request (always accepted)
- wbAddr  in  ADDR_W  writeback register
- wbData  in  DATA_W  writeback value
- rfReadAddr1, rfReadAddr2  out  ADDR_W  to register file; combinational copy of issueSrc1/2
- rfReadData1, rfReadData2  in  DATA_W  register file combinational read data
- rfWriteAddr  out  ADDR_W  combinational copy of wbAddr
- rfWriteEnable  out  1  combinational copy of wbValid
- rfWriteData  out  DATA_W  combinational copy of wbData
- pendingMask  out  2^ADDR_W  scoreboard, bit i = write to register i outstanding
- stallCount  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- The register file reads combinationally and writes at the rising edge. A read of the register being written in the same cycle returns the old value.
- The output stage has two states:
  - EMPTY: opValid=0.
  - FULL: opValid=1.
  - EMPTY→FULL on issue accept.
  - FULL→EMPTY when opReady is high and there is no accept.
  - FULL stays FULL when opReady is high and an accept happens in the same cycle (back-to-back, one bundle per cycle).
  - FULL with opReady low holds all op* outputs stable.
- A source hazard exists for srcN when pendingMask[srcN] is high, except when the bypass is enabled and it hits (see Configuration).
- A WAW hazard exists when issueWrites is high and pendingMask[issueDst] is high.
- issueReady = (!opValid || opReady) && no source hazard && no WAW hazard.
  - issueReady depends on the issue payload. Upstream must hold the payload stable while issueValid is high.
- On accept:
  - opDataN is taken from rfReadDataN, or from wbData on a bypass hit.
  - opDst and opWrites are registered.
  - If issueWrites is high, pendingMask[issueDst] is set.
- On wbValid, pendingMask[wbAddr] is cleared.
  - Same-cycle set and clear of the same bit: set wins.
  - Writeback to a register that is not pending still writes the file and leaves the scoreboard unchanged.
- stallCount increments on each cycle with issueValid && !issueReady caused by a hazard. Backpressure-only stalls do not count. The counter saturates at all-ones.

## Timing
- Reset (asynchronous assert) sets opValid=0, opData1/2=0, opDst=0, opWrites=0, pendingMask=0, stallCount=0.
  - rfWriteEnable follows wbValid combinationally, including during reset.
- Reset mid-operation drops any held bundle and clears the scoreboard. Writebacks in flight at that point are ignored by the scoreboard.
- Issue-to-opValid latency: 1 cycle.
- Without bypass, a dependent instruction issued while its producer's wb is in cycle T is accepted at T+1 at the earliest, and reads the new value from the file.
- With bypass, it is accepted in cycle T.
- Both sources may hazard or bypass independently.
- src1 == src2 is legal and yields identical operands.

## Configuration
- OFU_WB_BYPASS_EN defined:
  - A pending source is not a hazard when wbValid is high and wbAddr matches it in the same cycle.
  - The operand is taken from wbData.
- Not defined:
  - Any pending source stalls.
  - The bypass mux is absent and opDataN always comes from rfReadDataN.

## Test plan
- Preload r6=70, r2=30; issue src1=6, src2=2, dst=5, writes=1 -> next cycle opValid=1, opData1=70, opData2=30, opDst=5, pendingMask[5]=1.
- With r5 pending, issue src1=5 -> issueReady=0 and stallCount increments each cycle. Then wbValid, wbAddr=5, wbData=100:
  - with OFU_WB_BYPASS_EN: accepted in that cycle with opData1=100.
  - without it: accepted the next cycle with opData1=100 read from the file; pendingMask[5]=0.
- Hold opReady=0 with opValid=1 and issueValid=1 -> issueReady=0, op* stable, stallCount unchanged. Then raise opReady -> the new bundle replaces the old one the next cycle with no bubble.
- Issue dst=3 writes=1 twice with no wb in between -> second issue stalls on WAW until wbAddr=3, then is accepted and pendingMask[3] stays 1.
- Same-cycle issue dst=4 writes=1 with wbAddr=4 clearing an older non-pending write -> pendingMask[4]=1 afterwards.
- Assert rstN=0 asynchronously mid-stall with opValid=1 and pendingMask=0x0024 -> immediately opValid=0, pendingMask=0, stallCount=0, opData1/2=0.
